// File: rtl/io_stream_loader_pkg.sv
// Shared types and constants for the IO-pad stream loader.
// Contents: the loader state enum, the number of configuration beats and
// the slot index of each configuration field in the order the beats arrive.
package io_stream_loader_pkg;

    typedef enum logic [2:0] {
        CFG,
        INSTR,
        DATA,
        START,
        WAIT,
        UNLOAD
    } state_t;

    localparam int NUM_CFG = 5;

    // Configuration beat order on the input stream
    localparam int CFG_INSTR_MAX = 0;
    localparam int CFG_IN_MAX    = 1;
    localparam int CFG_IN_OFF    = 2;
    localparam int CFG_OUT_MAX   = 3;
    localparam int CFG_OUT_OFF   = 4;

endpackage

// File: rtl/stream_packer.sv
// Packs IN_W-bit beats into WORD_W-bit words, low chunk first.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (drops any partial word)
//   beat_vld    - a beat is being consumed this cycle
//   beat_data   - the beat
//   last_beat   - combinational: this beat completes a word
//   word_vld    - registered one-cycle pulse the cycle after the last beat
//   word        - assembled word, valid while word_vld is high
module stream_packer #(
    parameter int IN_W   = 16,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_vld,
    input  logic [IN_W-1:0]   beat_data,
    output logic              last_beat,
    output logic              word_vld,
    output logic [WORD_W-1:0] word
);

    localparam int BEATS = WORD_W / IN_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] sh_q, sh_d, sh_next;
    logic              word_vld_q, word_vld_d;

    // New beats enter at the top so the first beat ends up in the low chunk.
    if (BEATS == 1) begin : g_one
        assign sh_next = beat_data;
    end else begin : g_multi
        assign sh_next = {beat_data, sh_q[WORD_W-1:IN_W]};
    end

    assign last_beat = beat_vld && (cnt_q == CW'(BEATS - 1));

    always_comb begin
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        word_vld_d = last_beat;
        if (beat_vld) begin
            sh_d  = sh_next;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            word_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            word_vld_q <= word_vld_d;
        end
    end

    // The shift register already holds the complete word in the pulse cycle;
    // a following beat only changes it at the end of that cycle.
    assign word_vld = word_vld_q;
    assign word     = sh_q;

endmodule

// File: rtl/io_stream_loader.sv
// Pad-side loader/unloader between the IO stream and accelerator memories.
// Input stream: 5 config beats, then instruction words, then data words.
// Words are written to instruction / data memory, start is pulsed, and after
// done the output region is read back and serialised onto the output stream.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   in_data/in_vld/in_rdy            - IN_W-bit input stream
//   out_data/out_vld/out_rdy         - OUT_W-bit output stream
//   instr_wen/instr_wadr/instr_wdata - instruction memory write
//   mem_wen/mem_wadr/mem_wdata       - data memory write
//   mem_ren/mem_radr/mem_rdata       - data memory read (1-cycle latency)
//   start/done                       - accelerator handshake
module io_stream_loader
    import io_stream_loader_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_vld,
    output logic               in_rdy,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               instr_wen,
    output logic [ADDR_W-1:0]  instr_wadr,
    output logic [INSTR_W-1:0] instr_wdata,
    output logic               mem_wen,
    output logic [ADDR_W-1:0]  mem_wadr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_ren,
    output logic [ADDR_W-1:0]  mem_radr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               start,
    input  logic               done
);

    localparam int OBEATS = DATA_W / OUT_W;
    localparam int OCW    = (OBEATS > 1) ? $clog2(OBEATS) : 1;

    state_t                         state_q, state_d;
    logic [NUM_CFG-1:0][ADDR_W-1:0] cfg_q, cfg_d;
    logic [2:0]                     cfg_cnt_q, cfg_cnt_d;
    logic [ADDR_W:0]                idx_q, idx_d;
    logic [ADDR_W-1:0]              instr_wadr_q, instr_wadr_d;
    logic [ADDR_W-1:0]              mem_wadr_q, mem_wadr_d;
    logic [ADDR_W-1:0]              mem_radr_q, mem_radr_d;
    logic                           mem_ren_q, mem_ren_d;
    logic                           rd_vld_q;
    logic                           start_q, start_d;
    logic                           out_vld_q, out_vld_d;
    logic [DATA_W-1:0]              osh_q, osh_d;
    logic [OCW-1:0]                 obeat_q, obeat_d;
    logic                           instr_beat, data_beat, instr_last, data_last;

    assign in_rdy     = state_q inside {CFG, INSTR, DATA};
    assign instr_beat = in_vld && (state_q == INSTR);
    assign data_beat  = in_vld && (state_q == DATA);

    stream_packer #(.IN_W(IN_W), .WORD_W(INSTR_W)) u_instr_pack (
        .clk(clk), .rst(rst), .beat_vld(instr_beat), .beat_data(in_data),
        .last_beat(instr_last), .word_vld(instr_wen), .word(instr_wdata)
    );

    stream_packer #(.IN_W(IN_W), .WORD_W(DATA_W)) u_data_pack (
        .clk(clk), .rst(rst), .beat_vld(data_beat), .beat_data(in_data),
        .last_beat(data_last), .word_vld(mem_wen), .word(mem_wdata)
    );

    // State moves on the last *beat* of the last word, so the next stream
    // beat is already routed to the right packer while the write is still
    // pending; the write address is latched alongside the packer pulse.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        cfg_cnt_d    = cfg_cnt_q;
        idx_d        = idx_q;
        instr_wadr_d = instr_wadr_q;
        mem_wadr_d   = mem_wadr_q;
        mem_radr_d   = mem_radr_q;
        mem_ren_d    = 1'b0;
        start_d      = 1'b0;
        out_vld_d    = out_vld_q;
        osh_d        = osh_q;
        obeat_d      = obeat_q;
        unique case (state_q)
            CFG: if (in_vld) begin
                cfg_d[cfg_cnt_q] = in_data[ADDR_W-1:0];
                if (cfg_cnt_q == 3'(NUM_CFG - 1)) begin
                    cfg_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = INSTR;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + 3'd1;
                end
            end
            INSTR: if (instr_last) begin
                instr_wadr_d = idx_q[ADDR_W-1:0];
                if (idx_q == {1'b0, cfg_q[CFG_INSTR_MAX]}) begin
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DATA: if (data_last) begin
                mem_wadr_d = cfg_q[CFG_IN_OFF] + idx_q[ADDR_W-1:0];
                if (idx_q == {1'b0, cfg_q[CFG_IN_MAX]}) begin
                    idx_d   = '0;
                    state_d = START;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            // START coincides with the final data write; start rises one
            // cycle later so the accelerator never sees a half-written memory.
            START: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (done) begin
                state_d    = UNLOAD;
                idx_d      = '0;
                mem_ren_d  = 1'b1;
                mem_radr_d = cfg_q[CFG_OUT_OFF];
            end
            UNLOAD: begin
                if (rd_vld_q) begin
                    osh_d     = mem_rdata;
                    out_vld_d = 1'b1;
                    obeat_d   = '0;
                end else if (out_vld_q && out_rdy) begin
                    osh_d = osh_q >> OUT_W;
                    if (obeat_q == OCW'(OBEATS - 1)) begin
                        out_vld_d = 1'b0;
                        obeat_d   = '0;
                        if (idx_q == {1'b0, cfg_q[CFG_OUT_MAX]}) begin
                            idx_d   = '0;
                            state_d = CFG;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            mem_ren_d  = 1'b1;
                            mem_radr_d = cfg_q[CFG_OUT_OFF] + idx_q[ADDR_W-1:0] + ADDR_W'(1);
                        end
                    end else begin
                        obeat_d = obeat_q + 1'b1;
                    end
                end
            end
            default: state_d = CFG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CFG;
            cfg_q        <= '0;
            cfg_cnt_q    <= '0;
            idx_q        <= '0;
            instr_wadr_q <= '0;
            mem_wadr_q   <= '0;
            mem_radr_q   <= '0;
            mem_ren_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            start_q      <= 1'b0;
            out_vld_q    <= 1'b0;
            osh_q        <= '0;
            obeat_q      <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            cfg_cnt_q    <= cfg_cnt_d;
            idx_q        <= idx_d;
            instr_wadr_q <= instr_wadr_d;
            mem_wadr_q   <= mem_wadr_d;
            mem_radr_q   <= mem_radr_d;
            mem_ren_q    <= mem_ren_d;
            rd_vld_q     <= mem_ren_q;   // read data is valid one cycle after the strobe
            start_q      <= start_d;
            out_vld_q    <= out_vld_d;
            osh_q        <= osh_d;
            obeat_q      <= obeat_d;
        end
    end

    assign instr_wadr = instr_wadr_q;
    assign mem_wadr   = mem_wadr_q;
    assign mem_radr   = mem_radr_q;
    assign mem_ren    = mem_ren_q;
    assign start      = start_q;
    assign out_vld    = out_vld_q;
    assign out_data   = osh_q[OUT_W-1:0];

endmodule
